// File: rtl/ice_unlock_pkg.sv
// Shared types and constants for the ICE unlock controller: FSM states,
// register offsets, STATUS/CTRL bit positions and the unlock key table.
package ice_unlock_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_STEP    = 2'd1,
    ST_UNLK    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  localparam logic [31:0] OFS_DATA   = 32'h0;
  localparam logic [31:0] OFS_STATUS = 32'h4;
  localparam logic [31:0] OFS_CTRL   = 32'h8;

  localparam int ST_UNLK_BIT  = 0;
  localparam int ST_LO_BIT    = 1;
  localparam int ST_STEP_LSB  = 4;
  localparam int ST_FAIL_LSB  = 8;
  localparam int ST_TMO_BIT   = 12;

  localparam int CTRL_RELOCK_BIT  = 0;
  localparam int CTRL_CLRFAIL_BIT = 1;

  // Key i lives in ICEUNLK_KEYS[i]; only the DW LSBs are compared.
  localparam logic [3:0][31:0] ICEUNLK_KEYS = {
    32'h0f1e_2d3c, 32'hc3c3_3c3c, 32'h5a5a_a5a5, 32'hffae_6832
  };

endpackage

// File: rtl/ice_wr_sync.sv
// Brings an asynchronous active-low write strobe into the local clock domain
// and emits a one-cycle pulse per falling edge.
module ice_wr_sync (
  input  logic clk,
  input  logic rst,
  input  logic wr_n_async,
  output logic wr_pulse
);

  logic s1_q, s2_q, prev_q;

  // Flops reset high so an idle strobe never produces a spurious pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= wr_n_async;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign wr_pulse = !s2_q && prev_q;

endmodule

// File: rtl/ice_unlock_ctl.sv
// ICE security control: register window decode, multi-key unlock FSM with
// failure counting and lockout. Optional step timeout under ICEUNLK_TIMEOUT_EN.
module ice_unlock_ctl
  import ice_unlock_pkg::*;
#(
  parameter int              DW        = 32,
  parameter int              AW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h0400_0000,
  parameter int              NKEY      = 2,
  parameter int              MAXFAIL   = 3,
  parameter int              TMO_CYC   = 1024
) (
  input  logic          FCLKRT,
  input  logic          SYSRSOUT,
  input  logic [AW-1:0] ICEIFA,
  input  logic [DW-1:0] ICEDI,
  input  logic          ICEWR,
  input  logic          ICEMSKCKSMER,
  input  logic          CKSMER,
  input  logic          PSEUDOCKSMER,
  input  logic          CSPDTFLP,
  output logic          ICECKSMER,
  output logic          CSPDTFLG,
  output logic [DW-1:0] ICEDOP,
  output logic          UNLOCKED,
  output logic          LOCKOUT
);

  localparam logic [AW-3:0] BASE_W = BASE_ADDR[AW-1:2];

  logic          wr_pulse;
  state_e        state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [3:0]    fail_q, fail_d;
  logic [DW-1:0] data_q, data_d;
  logic          tmo_flag;

  ice_wr_sync u_sync (
    .clk        (FCLKRT),
    .rst        (SYSRSOUT),
    .wr_n_async (ICEWR),
    .wr_pulse   (wr_pulse)
  );

  logic hit_data, hit_status, hit_ctrl;
  assign hit_data   = ICEIFA[AW-1:2] == BASE_W + (AW-2)'(OFS_DATA >> 2);
  assign hit_status = ICEIFA[AW-1:2] == BASE_W + (AW-2)'(OFS_STATUS >> 2);
  assign hit_ctrl   = ICEIFA[AW-1:2] == BASE_W + (AW-2)'(OFS_CTRL >> 2);

  logic [DW-1:0] key_cur, key_last;
  assign key_cur  = ICEUNLK_KEYS[step_q][DW-1:0];
  assign key_last = ICEUNLK_KEYS[NKEY-1][DW-1:0];

`ifdef ICEUNLK_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_flag_q, tmo_flag_d;
  assign tmo_flag = tmo_flag_q;
`else
  logic unused_bits;
  assign tmo_flag    = 1'b0;
  assign unused_bits = &{1'b0, ICEIFA[1:0], TMO_CYC[0]};
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    fail_d  = fail_q;
    data_d  = data_q;
`ifdef ICEUNLK_TIMEOUT_EN
    tmo_flag_d = tmo_flag_q;
    tmo_cnt_d  = (state_q == ST_STEP && !wr_pulse) ? tmo_cnt_q + 1'b1 : '0;
    // A write in the same cycle takes precedence over the timeout.
    if (state_q == ST_STEP && !wr_pulse && tmo_cnt_q == TW'(TMO_CYC - 1)) begin
      state_d    = ST_LOCKED;
      step_d     = '0;
      tmo_flag_d = 1'b1;
    end
`endif
    if (wr_pulse && state_q != ST_LOCKOUT) begin
      if (hit_data) begin
        if (state_q == ST_UNLK) begin
          data_d = ICEDI;
          if (ICEDI != key_last) state_d = ST_LOCKED;
        end else if (ICEDI == key_cur) begin
          data_d = ICEDI;
          if (step_q == 2'(NKEY - 1)) begin
            state_d = ST_UNLK;
            step_d  = '0;
          end else begin
            state_d = ST_STEP;
            step_d  = step_q + 2'd1;
          end
        end else begin
          step_d  = '0;
          fail_d  = (fail_q == 4'hf) ? fail_q : fail_q + 4'd1;
          state_d = ({1'b0, fail_q} + 5'd1 == 5'(MAXFAIL)) ? ST_LOCKOUT : ST_LOCKED;
        end
      end else if (hit_ctrl) begin
        if (ICEDI[CTRL_CLRFAIL_BIT] && state_q == ST_UNLK) fail_d = '0;
        if (ICEDI[CTRL_RELOCK_BIT]) begin
          state_d = ST_LOCKED;
          step_d  = '0;
`ifdef ICEUNLK_TIMEOUT_EN
          tmo_flag_d = 1'b0;
`endif
        end
      end
    end
  end

  always_ff @(posedge FCLKRT or posedge SYSRSOUT) begin
    if (SYSRSOUT) begin
      state_q <= ST_LOCKED;
      step_q  <= '0;
      fail_q  <= '0;
      data_q  <= '0;
`ifdef ICEUNLK_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      fail_q  <= fail_d;
      data_q  <= data_d;
`ifdef ICEUNLK_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
`endif
    end
  end

  logic [31:0] status;
  always_comb begin
    status = '0;
    status[ST_UNLK_BIT]              = UNLOCKED;
    status[ST_LO_BIT]                = LOCKOUT;
    status[ST_STEP_LSB +: 2]         = step_q;
    status[ST_FAIL_LSB +: 4]         = fail_q;
    status[ST_TMO_BIT]               = tmo_flag;
  end

  always_comb begin
    ICEDOP = '0;
    if (hit_data && state_q == ST_UNLK) ICEDOP = data_q;
    else if (hit_status)                ICEDOP = status[DW-1:0];
  end

  assign UNLOCKED  = state_q == ST_UNLK;
  assign LOCKOUT   = state_q == ST_LOCKOUT;
  assign CSPDTFLG  = CSPDTFLP & UNLOCKED;
  assign ICECKSMER = PSEUDOCKSMER | (ICEMSKCKSMER & CKSMER);

endmodule

// File: tb/tb_ice_unlock_ctl.sv
// Self-checking bench for ice_unlock_ctl: table of ICE writes with expected
// state queued per write, plus hand sequences for latency, reset and timeout.
module tb_ice_unlock_ctl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] A_DATA = 32'h0400_0000;
  localparam logic [31:0] A_STAT = 32'h0400_0004;
  localparam logic [31:0] A_CTRL = 32'h0400_0008;
  localparam logic [31:0] K0 = 32'hffae_6832;
  localparam logic [31:0] K1 = 32'h5a5a_a5a5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] iceifa = '0;
  logic [DW-1:0] icedi = '0;
  logic          icewr = 1'b1;
  logic          mskck = 1'b0, cksmer = 1'b0, pseudo = 1'b0, cspdtflp = 1'b0;
  logic          iceck, cspdtflg, unlocked, lockout;
  logic [DW-1:0] icedop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ice_unlock_ctl #(.DW(DW), .AW(AW), .BASE_ADDR(32'h0400_0000), .NKEY(2),
                   .MAXFAIL(3), .TMO_CYC(16)) dut (
    .FCLKRT(clk), .SYSRSOUT(rst), .ICEIFA(iceifa), .ICEDI(icedi), .ICEWR(icewr),
    .ICEMSKCKSMER(mskck), .CKSMER(cksmer), .PSEUDOCKSMER(pseudo),
    .CSPDTFLP(cspdtflp), .ICECKSMER(iceck), .CSPDTFLG(cspdtflg),
    .ICEDOP(icedop), .UNLOCKED(unlocked), .LOCKOUT(lockout)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] st;
    logic        unl;
    logic        lo;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic [31:0] st;
    logic        unl;
    logic        lo;
    logic [31:0] rdata;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic read(input logic [31:0] a, output logic [31:0] d);
    iceifa = a;
    #1;
    d = icedop;
  endtask

  // Holds address/data through 4 edges, then leaves the strobe high long
  // enough for the synchroniser to see the rising edge before the next write.
  task automatic ice_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    iceifa = a; icedi = d; icewr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    icewr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    icewr = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] st, input logic unl,
                              input logic lo, input logic [31:0] rd);
    vec_t v;
    v.addr = a; v.wdata = d; v.st = st; v.unl = unl; v.lo = lo; v.rdata = rd;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    exp_t e;
    int seen;

    tbl.push_back(mk(A_DATA, K0,           32'h010, 0, 0, 0));
    tbl.push_back(mk(A_DATA, K1,           32'h001, 1, 0, K1));
    tbl.push_back(mk(A_STAT, 32'hff,       32'h001, 1, 0, K1));
    tbl.push_back(mk(A_DATA, K1,           32'h001, 1, 0, K1));
    tbl.push_back(mk(A_CTRL, 32'h1,        32'h000, 0, 0, 0));
    tbl.push_back(mk(A_DATA, K0,           32'h010, 0, 0, 0));
    tbl.push_back(mk(A_DATA, 32'h12345678, 32'h100, 0, 0, 0));
    tbl.push_back(mk(A_CTRL, 32'h2,        32'h100, 0, 0, 0));
    tbl.push_back(mk(A_DATA, K1,           32'h200, 0, 0, 0));
    tbl.push_back(mk(A_DATA, K0,           32'h210, 0, 0, 0));
    tbl.push_back(mk(A_DATA, K1,           32'h201, 1, 0, K1));
    tbl.push_back(mk(A_CTRL, 32'h2,        32'h001, 1, 0, K1));
    tbl.push_back(mk(A_DATA, 32'hdead,     32'h000, 0, 0, 0));
    tbl.push_back(mk(32'h0400_0010, K0,    32'h000, 0, 0, 0));
    tbl.push_back(mk(32'h0400_0003, K0,    32'h010, 0, 0, 0));
    tbl.push_back(mk(A_DATA, K1,           32'h001, 1, 0, K1));
    tbl.push_back(mk(A_CTRL, 32'h1,        32'h000, 0, 0, 0));
    tbl.push_back(mk(A_DATA, 32'h1,        32'h100, 0, 0, 0));
    tbl.push_back(mk(A_DATA, K0,           32'h110, 0, 0, 0));
    tbl.push_back(mk(A_DATA, K1,           32'h101, 1, 0, K1));
    tbl.push_back(mk(A_CTRL, 32'h3,        32'h000, 0, 0, 0));
    tbl.push_back(mk(A_DATA, 32'h1,        32'h100, 0, 0, 0));
    tbl.push_back(mk(A_DATA, 32'h2,        32'h200, 0, 0, 0));
    tbl.push_back(mk(A_DATA, K0,           32'h210, 0, 0, 0));
    tbl.push_back(mk(A_DATA, 32'h3,        32'h302, 0, 1, 0));
    tbl.push_back(mk(A_DATA, K0,           32'h302, 0, 1, 0));
    tbl.push_back(mk(A_DATA, K1,           32'h302, 0, 1, 0));
    tbl.push_back(mk(A_CTRL, 32'h1,        32'h302, 0, 1, 0));

    // Reset state
    do_reset();
    read(A_STAT, rd);   chk("reset_status", rd, 32'h0);
    chk("reset_unlocked", {31'b0, unlocked}, 32'h0);
    chk("reset_lockout", {31'b0, lockout}, 32'h0);
    cspdtflp = 1'b1; #1;
    chk("reset_cspdtflg", {31'b0, cspdtflg}, 32'h0);

    // Table: expectation queued when the write is driven, popped once it lands
    seen = 0;
    foreach (tbl[i]) begin
      sbq.push_back('{st: tbl[i].st, unl: tbl[i].unl, lo: tbl[i].lo, rdata: tbl[i].rdata});
      ice_write(tbl[i].addr, tbl[i].wdata);
      e = sbq.pop_front();
      seen++;
      read(A_STAT, rd); chk($sformatf("v%0d_status", i), rd, e.st);
      read(A_DATA, rd); chk($sformatf("v%0d_data", i), rd, e.rdata);
      read(A_CTRL, rd); chk($sformatf("v%0d_ctrl", i), rd, 32'h0);
      chk($sformatf("v%0d_unlocked", i), {31'b0, unlocked}, {31'b0, e.unl});
      chk($sformatf("v%0d_lockout", i), {31'b0, lockout}, {31'b0, e.lo});
      chk($sformatf("v%0d_cspdtflg", i), {31'b0, cspdtflg}, {31'b0, e.unl});
    end
    chk("sb_drained", seen, tbl.size());

    // Lockout cleared only by reset
    do_reset();
    read(A_STAT, rd); chk("lockout_reset_status", rd, 32'h0);
    chk("lockout_reset_lo", {31'b0, lockout}, 32'h0);

    // Unlock latency: UNLOCKED rises on the third edge after ICEWR is low
    ice_write(A_DATA, K0);
    @(negedge clk);
    iceifa = A_DATA; icedi = K1; icewr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lat_before", {31'b0, unlocked}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_edge3", {31'b0, unlocked}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    icewr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    read(A_DATA, rd); chk("lat_data", rd, K1);

    // Reset mid-sequence aborts to reset values
    do_reset();
    ice_write(A_DATA, K0);
    read(A_STAT, rd); chk("mid_step", rd, 32'h010);
    do_reset();
    read(A_STAT, rd); chk("mid_reset_status", rd, 32'h0);

    // Idle in STEP: timeout relocks with sticky flag, otherwise STEP persists
    ice_write(A_DATA, K0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    read(A_STAT, rd);
`ifdef ICEUNLK_TIMEOUT_EN
    chk("idle_step_status", rd, 32'h1000);
    ice_write(A_CTRL, 32'h1);
    read(A_STAT, rd); chk("tmo_flag_clear", rd, 32'h0);
`else
    chk("idle_step_status", rd, 32'h010);
`endif

    // Second key whose pulse coincides with the timeout cycle still unlocks
    do_reset();
    ice_write(A_DATA, K0);
    repeat (9) @(posedge clk);
    ice_write(A_DATA, K1);
    chk("tmo_race_unlocked", {31'b0, unlocked}, 32'h1);

    // Checksum-error combine over all 8 input combinations
    for (int c = 0; c < 8; c++) begin
      logic [2:0] cv;
      logic expv;
      cv = 3'(c);
      {pseudo, mskck, cksmer} = cv;
      expv = cv[2] | (cv[1] & cv[0]);
      #1;
      chk($sformatf("cksm_%0d", c), {31'b0, iceck}, {31'b0, expv});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
